memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Shares the single-port unified RAM between the instruction-fetch port and the data port of the pipelined CPU.
//  Data accesses win by default; a streak limiter guarantees fetch forward progress.
//  ihit/dhit feed the pipeline hazard/stall logic.
//  Sits between the datapath's fetch/mem stages and the RAM model.
//  Registered FSM, one access outstanding at a time.
// PARAMETERS
//  MAX_DSTREAK  4    consecutive data grants allowed while a fetch waits (>=1)
//  TIMEOUT      64   cycles in an access state without ram_ready before abort (>=2)
// PORTS
//  CLK        in   1   system clock, all state on rising edge
//  RST        in   1   synchronous reset, active-high
//  iREN       in   1   fetch request, held until ihit
//  iaddr      in   32  fetch word address
//  dREN       in   1   data read request, held until dhit
//  dWEN       in   1   data write request, held until dhit
//  daddr      in   32  data address
//  dstore     in   32  data write value
//  ihit       out  1   one-cycle pulse: fetch complete, iload valid same cycle
//  dhit       out  1   one-cycle pulse: data access complete, dload valid same cycle
//  iload      out  32  fetched instruction, held until next ihit
//  dload      out  32  loaded data, held until next dhit (unchanged on writes)
//  ramREN     out  1   RAM read strobe
//  ramWEN     out  1   RAM write strobe
//  ramaddr    out  32  RAM address (latched)
//  ramstore   out  32  RAM write data (latched)
//  ramload    in   32  RAM read data, valid when ram_ready
//  ram_ready  in   1   RAM access complete this cycle
//  err        out  1   one-cycle pulse: access aborted by TIMEOUT
// BEHAVIOUR
//  Reset: state=IDLE, streak=0, tmo=0, all outputs 0 (incl. iload, dload, ramaddr, ramstore).
//  States: IDLE, IACC, DACC.
//  IDLE:
//    - dreq=(dREN|dWEN) and (streak<MAX_DSTREAK or !iREN) -> DACC; latch daddr/dstore, op=WRITE if dWEN else READ.
//    - else iREN -> IACC; latch iaddr.
//    - else stay.
//    - dREN&dWEN together -> WRITE.
//  DACC/IACC:
//    - Drive ramaddr from latch; ramREN=1 for READ/IACC, ramWEN=1 for WRITE; never both.
//    - Strobes are 0 in IDLE.
//    - ram_ready=1 -> next cycle: state=IDLE, hit pulse for that port; on reads capture ramload into iload/dload.
//  Latency: request high in IDLE at cycle 0 -> strobe cycle 1 -> ram_ready cycle k (k>=1) -> hit cycle k+1 (min 2).
//    - Back-to-back: next grant evaluated in the hit cycle; strobes resume the cycle after.
//  Streak counter:
//    - +1 (saturating at MAX_DSTREAK) on each DACC grant while iREN=1.
//    - Cleared on IACC grant, or in IDLE when iREN=0.
//    - streak==MAX_DSTREAK with iREN=1 forces IACC over a data request.
//  Timeout counter:
//    - Clears on entry to an access state, increments each cycle there.
//    - Reaching TIMEOUT-1 without ram_ready -> IDLE next cycle, err pulse, no hit, load regs unchanged.
//  Request dropped mid-access: access completes normally, hit still pulses; requester ignores it.
//  Request signals are sampled only in IDLE; address/data changes during an access have no effect.
//  RST mid-access: aborts immediately, no hit/err pulse, strobes low next cycle.
// TESTING
//  1. Lone fetch iaddr=0x40, ram_ready 1 cycle after strobe with ramload=0x8C220004 -> ihit at cycle 2, iload=0x8C220004.
//  2. iREN&dREN together, streak=0 -> DACC first, dhit; then IACC, ihit; ramREN never overlaps ramWEN.
//  3. dWEN held continuously with iREN, MAX_DSTREAK=4 -> 4 dhits, then 1 ihit, repeating; streak never exceeds 4.
//  4. dREN&dWEN, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dload unchanged.
//  5. ram_ready stuck low, TIMEOUT=64 -> err pulse 64 cycles after strobe, state IDLE, no hit.
//  6. RST asserted mid-DACC -> all outputs 0 next cycle; subsequent fetch completes normally.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// memory_arbiter_if
//   Groups the fetch port, data port and RAM port signals of the unified-memory
//   arbiter. The arbiter binds to the "slave" modport. The surrounding
//   datapath/RAM environment binds to the "master" modport.
//
//   Fetch port : iREN, iaddr        -> ihit, iload
//   Data port  : dREN, dWEN, daddr, dstore -> dhit, dload
//   RAM port   : ramload, ram_ready -> ramREN, ramWEN, ramaddr, ramstore
//   Status     : err (access aborted by timeout)
// -----------------------------------------------------------------------------
interface memory_arbiter_if;

   // fetch port
   logic        iREN;
   logic [31:0] iaddr;
   logic        ihit;
   logic [31:0] iload;

   // data port
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dhit;
   logic [31:0] dload;

   // RAM port
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic        ram_ready;

   // status
   logic        err;

   // arbiter side
   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
      output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );

   // requester / RAM side
   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
      input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );

endinterface

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//   Shares one single-port unified RAM between the instruction-fetch port and
//   the data port of the pipelined CPU. One access is outstanding at a time.
//   Data requests win by default. A streak counter limits how many data grants
//   may be issued in a row while a fetch is waiting, so fetch always makes
//   forward progress. An access that never sees ram_ready is aborted after
//   TIMEOUT cycles and reported on err.
//
//   Parameters
//     MAX_DSTREAK : consecutive data grants allowed while a fetch waits (>=1)
//     TIMEOUT     : cycles in an access state without ram_ready before abort (>=2)
//
//   Ports
//     CLK : system clock, all state updates on the rising edge
//     RST : synchronous reset, active-high
//     bus : memory_arbiter_if.slave
//           requests in  : iREN/iaddr, dREN/dWEN/daddr/dstore
//           completion out: ihit/iload, dhit/dload (hit pulses one cycle)
//           RAM out      : ramREN, ramWEN, ramaddr, ramstore (all registered)
//           RAM in       : ramload, ram_ready
//           err out      : one-cycle pulse when an access times out
//
//   Timing: a request seen in IDLE in cycle 0 drives the RAM strobe in
//   cycle 1. ram_ready in cycle k gives the hit pulse in cycle k+1. The next
//   grant is evaluated in that hit cycle.
// -----------------------------------------------------------------------------
module memory_arbiter #(
   parameter int unsigned MAX_DSTREAK = 4,
   parameter int unsigned TIMEOUT     = 64
) (
   input  logic             CLK,
   input  logic             RST,
   memory_arbiter_if.slave  bus
);

   localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);
   localparam int unsigned TW = $clog2(TIMEOUT);

   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IACC = 2'd1,
      DACC = 2'd2
   } state_t;

   state_t         state_q;
   logic           op_write_q;   // latched data op: 1 = write, 0 = read
   logic [SW-1:0]  streak_q;     // data grants issued while a fetch was waiting
   logic [TW-1:0]  tmo_q;        // cycles spent in the current access state

   logic           ihit_q;
   logic           dhit_q;
   logic           err_q;
   logic [31:0]    iload_q;
   logic [31:0]    dload_q;
   logic           ram_ren_q;
   logic           ram_wen_q;
   logic [31:0]    ram_addr_q;
   logic [31:0]    ram_store_q;

   // Grant decision. It is only acted on in IDLE. Once the streak limit is
   // reached with a fetch pending, the data request is held off for one
   // fetch.
   logic dreq;
   logic grant_d;

   assign dreq    = bus.dREN | bus.dWEN;
   assign grant_d = dreq && ((streak_q < STREAK_MAX) || !bus.iREN);

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values, which avoids order-dependent simulation races.
   always_ff @(posedge CLK) begin
      if (RST) begin
         // NOTE: the load/address/data registers are reset along with the
         // control state because they are visible outputs and must read as
         // zero after reset.
         state_q     <= IDLE;
         op_write_q  <= 1'b0;
         streak_q    <= '0;
         tmo_q       <= '0;
         ihit_q      <= 1'b0;
         dhit_q      <= 1'b0;
         err_q       <= 1'b0;
         iload_q     <= '0;
         dload_q     <= '0;
         ram_ren_q   <= 1'b0;
         ram_wen_q   <= 1'b0;
         ram_addr_q  <= '0;
         ram_store_q <= '0;
      end else begin
         // status outputs are single-cycle pulses
         ihit_q <= 1'b0;
         dhit_q <= 1'b0;
         err_q  <= 1'b0;

         unique case (state_q)
            IDLE: begin
               if (grant_d) begin
                  state_q     <= DACC;
                  op_write_q  <= bus.dWEN;      // dREN & dWEN together is a write
                  ram_addr_q  <= bus.daddr;
                  ram_store_q <= bus.dstore;
                  ram_ren_q   <= ~bus.dWEN;
                  ram_wen_q   <= bus.dWEN;
                  tmo_q       <= '0;
                  if (bus.iREN) begin
                     if (streak_q != STREAK_MAX) begin
                        streak_q <= streak_q + 1'b1;
                     end
                  end else begin
                     streak_q <= '0;
                  end
               end else if (bus.iREN) begin
                  state_q    <= IACC;
                  ram_addr_q <= bus.iaddr;
                  ram_ren_q  <= 1'b1;
                  ram_wen_q  <= 1'b0;
                  tmo_q      <= '0;
                  streak_q   <= '0;
               end else begin
                  streak_q <= '0;
               end
            end

            IACC, DACC: begin
               if (bus.ram_ready) begin
                  state_q   <= IDLE;
                  ram_ren_q <= 1'b0;
                  ram_wen_q <= 1'b0;
                  if (state_q == IACC) begin
                     ihit_q  <= 1'b1;
                     iload_q <= bus.ramload;
                  end else begin
                     dhit_q <= 1'b1;
                     if (!op_write_q) begin
                        dload_q <= bus.ramload;
                     end
                  end
               end else if (tmo_q == TMO_LAST) begin
                  // Abort: no hit, and the load registers keep their values.
                  state_q   <= IDLE;
                  ram_ren_q <= 1'b0;
                  ram_wen_q <= 1'b0;
                  err_q     <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end

            default: begin
               state_q   <= IDLE;
               ram_ren_q <= 1'b0;
               ram_wen_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ihit     = ihit_q;
   assign bus.dhit     = dhit_q;
   assign bus.err      = err_q;
   assign bus.iload    = iload_q;
   assign bus.dload    = dload_q;
   assign bus.ramREN   = ram_ren_q;
   assign bus.ramWEN   = ram_wen_q;
   assign bus.ramaddr  = ram_addr_q;
   assign bus.ramstore = ram_store_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//   Directed bench for memory_arbiter (MAX_DSTREAK=4, TIMEOUT=64).
//   Inputs are driven and registered outputs are compared on the falling edge.
//   A table of per-cycle vectors covers single fetch, data/fetch contention,
//   a write, and requests changing mid-access. Hand-written sequences cover
//   the streak limiter, the timeout abort and reset in the middle of an access.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

   logic CLK;
   logic RST;

   memory_arbiter_if bus ();

   memory_arbiter #(
      .MAX_DSTREAK (4),
      .TIMEOUT     (64)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // One record per cycle: the inputs for that cycle and the outputs expected
   // in that same cycle.
   typedef struct packed {
      logic        iren;
      logic        dren;
      logic        dwen;
      logic [31:0] iaddr;
      logic [31:0] daddr;
      logic [31:0] dstore;
      logic        rdy;
      logic [31:0] rload;
      logic        ihit;
      logic        dhit;
      logic        err;
      logic        rren;
      logic        rwen;
      logic [31:0] raddr;
      logic [31:0] rstore;
      logic [31:0] iload;
      logic [31:0] dload;
   } vec_t;

   function automatic vec_t mk(
      input logic iren, input logic dren, input logic dwen,
      input logic [31:0] iaddr, input logic [31:0] daddr, input logic [31:0] dstore,
      input logic rdy, input logic [31:0] rload,
      input logic ihit, input logic dhit, input logic err,
      input logic rren, input logic rwen,
      input logic [31:0] raddr, input logic [31:0] rstore,
      input logic [31:0] iload, input logic [31:0] dload);
      vec_t v;
      v.iren = iren;   v.dren = dren;   v.dwen = dwen;
      v.iaddr = iaddr; v.daddr = daddr; v.dstore = dstore;
      v.rdy = rdy;     v.rload = rload;
      v.ihit = ihit;   v.dhit = dhit;   v.err = err;
      v.rren = rren;   v.rwen = rwen;
      v.raddr = raddr; v.rstore = rstore;
      v.iload = iload; v.dload = dload;
      return v;
   endfunction

   task automatic drive(input logic iren, input logic dren, input logic dwen,
                        input logic [31:0] iaddr, input logic [31:0] daddr,
                        input logic [31:0] dstore, input logic rdy,
                        input logic [31:0] rload);
      bus.iREN      = iren;
      bus.dREN      = dren;
      bus.dWEN      = dwen;
      bus.iaddr     = iaddr;
      bus.daddr     = daddr;
      bus.dstore    = dstore;
      bus.ram_ready = rdy;
      bus.ramload   = rload;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".ihit"},     32'(bus.ihit),   32'h0);
      check({tag, ".dhit"},     32'(bus.dhit),   32'h0);
      check({tag, ".err"},      32'(bus.err),    32'h0);
      check({tag, ".ramREN"},   32'(bus.ramREN), 32'h0);
      check({tag, ".ramWEN"},   32'(bus.ramWEN), 32'h0);
      check({tag, ".ramaddr"},  bus.ramaddr,     32'h0);
      check({tag, ".ramstore"}, bus.ramstore,    32'h0);
      check({tag, ".iload"},    bus.iload,       32'h0);
      check({tag, ".dload"},    bus.dload,       32'h0);
   endtask

   localparam int NV = 18;
   vec_t vecs [NV];

   // Watchdog: every loop below is bounded, this only guards against a stuck clock.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- per-cycle vector table ----------------
      // inputs: iren dren dwen iaddr daddr dstore rdy rload
      // expect: ihit dhit err ramREN ramWEN ramaddr ramstore iload dload
      // lone fetch at 0x40, RAM ready one cycle after the strobe
      vecs[0]  = mk(1'b1,1'b0,1'b0,32'h40,32'h0,32'h0,1'b0,32'h0,
                    1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,32'h0,32'h0);
      vecs[1]  = mk(1'b1,1'b0,1'b0,32'h40,32'h0,32'h0,1'b1,32'h8C220004,
                    1'b0,1'b0,1'b0,1'b1,1'b0,32'h40,32'h0,32'h0,32'h0);
      vecs[2]  = mk(1'b0,1'b0,1'b0,32'h0,32'h0,32'h0,1'b0,32'h0,
                    1'b1,1'b0,1'b0,1'b0,1'b0,32'h40,32'h0,32'h8C220004,32'h0);
      vecs[3]  = mk(1'b0,1'b0,1'b0,32'h0,32'h0,32'h0,1'b0,32'h0,
                    1'b0,1'b0,1'b0,1'b0,1'b0,32'h40,32'h0,32'h8C220004,32'h0);
      // fetch and data read together: data first (one wait state), then fetch
      vecs[4]  = mk(1'b1,1'b1,1'b0,32'h44,32'h200,32'h11111111,1'b0,32'h0,
                    1'b0,1'b0,1'b0,1'b0,1'b0,32'h40,32'h0,32'h8C220004,32'h0);
      vecs[5]  = mk(1'b1,1'b1,1'b0,32'h44,32'h200,32'h11111111,1'b0,32'h0,
                    1'b0,1'b0,1'b0,1'b1,1'b0,32'h200,32'h11111111,32'h8C220004,32'h0);
      vecs[6]  = mk(1'b1,1'b1,1'b0,32'h44,32'h200,32'h11111111,1'b1,32'h0000CAFE,
                    1'b0,1'b0,1'b0,1'b1,1'b0,32'h200,32'h11111111,32'h8C220004,32'h0);
      vecs[7]  = mk(1'b1,1'b0,1'b0,32'h44,32'h0,32'h0,1'b0,32'h0,
                    1'b0,1'b1,1'b0,1'b0,1'b0,32'h200,32'h11111111,32'h8C220004,32'h0000CAFE);
      vecs[8]  = mk(1'b1,1'b0,1'b0,32'h44,32'h0,32'h0,1'b1,32'h12345678,
                    1'b0,1'b0,1'b0,1'b1,1'b0,32'h44,32'h11111111,32'h8C220004,32'h0000CAFE);
      vecs[9]  = mk(1'b0,1'b0,1'b0,32'h0,32'h0,32'h0,1'b0,32'h0,
                    1'b1,1'b0,1'b0,1'b0,1'b0,32'h44,32'h11111111,32'h12345678,32'h0000CAFE);
      // dREN & dWEN together is a write; dload is untouched
      vecs[10] = mk(1'b0,1'b1,1'b1,32'h0,32'h100,32'hDEADBEEF,1'b0,32'h0,
                    1'b0,1'b0,1'b0,1'b0,1'b0,32'h44,32'h11111111,32'h12345678,32'h0000CAFE);
      vecs[11] = mk(1'b0,1'b1,1'b1,32'h0,32'h100,32'hDEADBEEF,1'b1,32'hFFFFFFFF,
                    1'b0,1'b0,1'b0,1'b0,1'b1,32'h100,32'hDEADBEEF,32'h12345678,32'h0000CAFE);
      vecs[12] = mk(1'b0,1'b0,1'b0,32'h0,32'h0,32'h0,1'b0,32'h0,
                    1'b0,1'b1,1'b0,1'b0,1'b0,32'h100,32'hDEADBEEF,32'h12345678,32'h0000CAFE);
      // fetch whose request/address change mid-access has no effect
      vecs[13] = mk(1'b1,1'b0,1'b0,32'h80,32'h0,32'h0,1'b0,32'h0,
                    1'b0,1'b0,1'b0,1'b0,1'b0,32'h100,32'hDEADBEEF,32'h12345678,32'h0000CAFE);
      vecs[14] = mk(1'b1,1'b1,1'b1,32'h999,32'h500,32'h55555555,1'b1,32'h0000000A,
                    1'b0,1'b0,1'b0,1'b1,1'b0,32'h80,32'hDEADBEEF,32'h12345678,32'h0000CAFE);
      vecs[15] = mk(1'b0,1'b0,1'b0,32'h0,32'h0,32'h0,1'b0,32'h0,
                    1'b1,1'b0,1'b0,1'b0,1'b0,32'h80,32'hDEADBEEF,32'h0000000A,32'h0000CAFE);
      // ram_ready while idle is ignored
      vecs[16] = mk(1'b0,1'b0,1'b0,32'h0,32'h0,32'h0,1'b1,32'h77777777,
                    1'b0,1'b0,1'b0,1'b0,1'b0,32'h80,32'hDEADBEEF,32'h0000000A,32'h0000CAFE);
      vecs[17] = mk(1'b0,1'b0,1'b0,32'h0,32'h0,32'h0,1'b0,32'h0,
                    1'b0,1'b0,1'b0,1'b0,1'b0,32'h80,32'hDEADBEEF,32'h0000000A,32'h0000CAFE);

      // ---------------- reset ----------------
      RST = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      repeat (3) @(negedge CLK);
      check_all_zero("reset");
      RST = 1'b0;

      // ---------------- table ----------------
      for (int i = 0; i < NV; i++) begin
         @(negedge CLK);
         drive(vecs[i].iren, vecs[i].dren, vecs[i].dwen, vecs[i].iaddr,
               vecs[i].daddr, vecs[i].dstore, vecs[i].rdy, vecs[i].rload);
         check($sformatf("v%0d.ihit", i),     32'(bus.ihit),   32'(vecs[i].ihit));
         check($sformatf("v%0d.dhit", i),     32'(bus.dhit),   32'(vecs[i].dhit));
         check($sformatf("v%0d.err", i),      32'(bus.err),    32'(vecs[i].err));
         check($sformatf("v%0d.ramREN", i),   32'(bus.ramREN), 32'(vecs[i].rren));
         check($sformatf("v%0d.ramWEN", i),   32'(bus.ramWEN), 32'(vecs[i].rwen));
         check($sformatf("v%0d.ramaddr", i),  bus.ramaddr,     vecs[i].raddr);
         check($sformatf("v%0d.ramstore", i), bus.ramstore,    vecs[i].rstore);
         check($sformatf("v%0d.iload", i),    bus.iload,       vecs[i].iload);
         check($sformatf("v%0d.dload", i),    bus.dload,       vecs[i].dload);
      end

      // ---------------- streak limiter ----------------
      // Write and fetch held continuously, RAM always ready: hits must follow
      // d d d d i, repeating.
      begin
         logic hit_i [32];
         int   n_hits  = 0;
         int   overlap = 0;
         @(negedge CLK);
         drive(1'b1, 1'b0, 1'b1, 32'h900, 32'h700, 32'h1, 1'b1, 32'h600D);
         for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (bus.ramREN && bus.ramWEN) overlap++;
            if ((bus.ihit || bus.dhit) && n_hits < 32) begin
               hit_i[n_hits] = bus.ihit;
               n_hits++;
            end
         end
         check("streak.hit_count_ge15", 32'(n_hits >= 15), 32'h1);
         for (int j = 0; j < 15; j++) begin
            if (j < n_hits) begin
               check($sformatf("streak.hit%0d_is_fetch", j), 32'(hit_i[j]), 32'((j % 5) == 4));
            end
         end
         check("streak.strobe_overlap", 32'(overlap), 32'h0);
      end

      // drain any access in flight, then settle in IDLE
      @(negedge CLK);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h600D);
      repeat (3) @(negedge CLK);
      bus.ram_ready = 1'b0;
      repeat (2) @(negedge CLK);

      // ---------------- timeout ----------------
      begin
         int err_at  = -1;
         int err_cnt = 0;
         int hits    = 0;
         drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h0, 1'b0, 32'h0);
         for (int k = 0; k < 70; k++) begin
            @(negedge CLK);
            if (k == 0) begin
               bus.dREN = 1'b0;   // dropped; the access keeps going
               check("tmo.strobe_start", 32'(bus.ramREN), 32'h1);
               check("tmo.ramaddr", bus.ramaddr, 32'h300);
            end
            if (k == 63) check("tmo.strobe_last", 32'(bus.ramREN), 32'h1);
            if (k == 64) check("tmo.strobe_off", 32'(bus.ramREN), 32'h0);
            if (bus.err) begin
               err_cnt++;
               if (err_at < 0) err_at = k;
            end
            if (bus.ihit || bus.dhit) hits++;
         end
         check("tmo.err_cycle", 32'(err_at), 32'd64);
         check("tmo.err_count", 32'(err_cnt), 32'd1);
         check("tmo.no_hit", 32'(hits), 32'd0);
         check("tmo.dload_kept", bus.dload, 32'h0000CAFE);
         check("tmo.iload_kept", bus.iload, 32'h0000600D);
      end

      // ---------------- reset in the middle of a data access ----------------
      @(negedge CLK);
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h400, 32'h0, 1'b0, 32'h0);
      @(negedge CLK);
      check("rstmid.in_dacc", 32'(bus.ramREN), 32'h1);
      RST = 1'b1;
      bus.dREN = 1'b0;
      @(negedge CLK);
      check_all_zero("rstmid");
      RST = 1'b0;

      // a fresh fetch after reset must complete with minimum latency
      begin
         int lat = 0;
         drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 32'h8C220004);
         for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (bus.ihit) begin
               lat = k;
               bus.iREN = 1'b0;
               break;
            end
         end
         check("postrst.ihit_latency", 32'(lat), 32'd2);
         check("postrst.iload", bus.iload, 32'h8C220004);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
